// File: rtl/keypad_scanner.sv
// keypad_scanner: N x M matrix keypad scanner. It strobes one row at a time,
// debounces every key over whole scan frames, and queues press/release events
// in a small FIFO that the game logic drains through a valid/ready handshake.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int KEYS      = ROWS * COLS,
    localparam int KW        = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] kp_col,
    output logic [ROWS-1:0] kp_row,
    output logic [KEYS-1:0] key_state,
    output logic            any_key,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic            evt_press,
    output logic [KW-1:0]   evt_code,
    output logic            evt_overflow
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {SCAN, UPDATE, EMIT} state_t;

    state_t          state, state_next;
    logic [RW-1:0]   row_idx;
    logic [DW-1:0]   dwell;
    logic [KEYS-1:0] raw;
    logic [KEYS-1:0] flip;
    logic [CW-1:0]   cnt [KEYS];

    logic            row_end, frame_end;
    logic [KEYS-1:0] state_upd, flip_upd;
    logic [CW-1:0]   cnt_upd [KEYS];
    logic [KEYS-1:0] emit_mask;
    logic            emit_press;
    logic [KW-1:0]   emit_code;

    logic [KW:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic            push, pop, full, accept;

    assign row_end   = (dwell == DW'(SETTLE - 1));
    assign frame_end = row_end && (row_idx == RW'(ROWS - 1));
    assign kp_row    = ~(ROWS'(1) << row_idx);
    assign any_key   = |key_state;

    // Frame-end debounce decision for every key, applied on the UPDATE edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_upd = key_state;
        flip_upd  = '0;
        for (int k = 0; k < KEYS; k++) begin
            cnt_upd[k] = '0;
            if (raw[k] != key_state[k]) begin
                if (cnt[k] == CW'(DEBOUNCE - 1)) begin
                    state_upd[k] = ~key_state[k];
                    flip_upd[k]  = 1'b1;
                end else begin
                    cnt_upd[k] = cnt[k] + CW'(1);
                end
            end
        end
    end

    // Lowest pending flip is the next event to emit (ascending code order).
    always_comb begin
        emit_mask  = '0;
        emit_press = 1'b0;
        emit_code  = '0;
        for (int k = KEYS - 1; k >= 0; k--) begin
            if (flip[k]) begin
                emit_mask    = '0;
                emit_mask[k] = 1'b1;
                emit_press   = key_state[k];
                emit_code    = KW'(k);
            end
        end
    end

    // Next-state logic: scan a full frame, update once, emit all flips.
    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (frame_end) state_next = UPDATE;
            UPDATE:  state_next = (|flip_upd) ? EMIT : SCAN;
            EMIT:    if ((flip & ~emit_mask) == '0) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= SCAN;
        else     state <= state_next;
    end

    // Row strobe / dwell counters and column sampling; row 0 held outside SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
            dwell   <= '0;
            raw     <= '0;
        end else if (state == SCAN) begin
            if (row_end) begin
                dwell   <= '0;
                row_idx <= frame_end ? '0 : row_idx + RW'(1);
                for (int k = 0; k < KEYS; k++) begin
                    if (k / COLS == int'(row_idx)) raw[k] <= ~kp_col[k % COLS];
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Debounced key levels, per-key frame counters and pending flips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= '0;
            flip      <= '0;
            for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
        end else begin
            case (state)
                UPDATE: begin
                    key_state <= state_upd;
                    flip      <= flip_upd;
                    for (int k = 0; k < KEYS; k++) cnt[k] <= cnt_upd[k];
                end
                EMIT:    flip <= flip & ~emit_mask;
                default: ;
            endcase
        end
    end

    assign push      = (state == EMIT);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count == NW'(FIFO_DEPTH));
    assign accept    = push && (!full || pop);
    assign evt_valid = (count != '0);
    assign evt_press = mem[rd_ptr][KW];
    assign evt_code  = mem[rd_ptr][KW-1:0];

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count <= count + NW'(accept) - NW'(pop);
            if (push && !accept) evt_overflow <= 1'b1;
        end
    end

    // FIFO storage; entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; emptiness is tracked by the reset pointers and count.
        if (accept) mem[wr_ptr] <= {emit_press, emit_code};
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated key matrix, compares the scanner every
// cycle against a frame-level behavioural model, and pins the model with a few
// hand-computed directed expectations.
module tb_keypad_scanner;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SETTLE     = 4;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int KEYS       = ROWS * COLS;
    localparam int KW         = $clog2(KEYS);
    localparam int RS         = ROWS * SETTLE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] kp_col;
    logic [ROWS-1:0] kp_row;
    logic [KEYS-1:0] key_state;
    logic            any_key;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic            evt_press;
    logic [KW-1:0]   evt_code;
    logic            evt_overflow;
    logic [KEYS-1:0] keys_down = '0;

    int n_checks = 0;
    int n_fails  = 0;
    int valid_cycles = 0;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE),
        .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
        .key_state(key_state), .any_key(any_key), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_press(evt_press), .evt_code(evt_code),
        .evt_overflow(evt_overflow)
    );

    initial forever #5 clk = ~clk;

    // Physical key matrix: a closed key pulls its column low while its row is strobed.
    always_comb begin
        kp_col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!kp_row[r] && keys_down[r*COLS+c]) kp_col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit press;
        int code;
    } ev_t;

    bit [KEYS-1:0] m_ks;
    bit [KEYS-1:0] m_raw;
    int            m_cnt [KEYS];
    int            m_pend [$];
    ev_t           m_fifo [$];
    bit            m_ovf;
    int            m_fpos;   // 0..RS-1 scanning, RS update, RS+1 emitting

    task automatic model_reset();
        m_ks  = '0;
        m_raw = '0;
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_pend.delete();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_fpos = 0;
    endtask

    task automatic model_step();
        bit  pop;
        ev_t ev;
        int  row;
        int  k;
        pop = (m_fifo.size() != 0) && evt_ready;
        if (pop) void'(m_fifo.pop_front());
        if (m_fpos < RS) begin
            if (m_fpos % SETTLE == SETTLE - 1) begin
                row = m_fpos / SETTLE;
                for (int c = 0; c < COLS; c++) m_raw[row*COLS+c] = keys_down[row*COLS+c];
            end
            m_fpos++;
        end else if (m_fpos == RS) begin
            for (int j = 0; j < KEYS; j++) begin
                if (m_raw[j] == m_ks[j]) m_cnt[j] = 0;
                else begin
                    m_cnt[j]++;
                    if (m_cnt[j] == DEBOUNCE) begin
                        m_ks[j]  = ~m_ks[j];
                        m_cnt[j] = 0;
                        m_pend.push_back(j);
                    end
                end
            end
            m_fpos = (m_pend.size() == 0) ? 0 : RS + 1;
        end else begin
            k = m_pend.pop_front();
            ev.press = m_ks[k];
            ev.code  = k;
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(ev);
            else m_ovf = 1'b1;
            if (m_pend.size() == 0) m_fpos = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    initial begin
        logic [ROWS-1:0] row_exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_fpos < RS) begin
                    row_exp = ~(ROWS'(1) << (m_fpos / SETTLE));
                    check("kp_row", kp_row, row_exp);
                end else if (m_fpos > RS) begin
                    row_exp = ~ROWS'(1);
                    check("kp_row_emit", kp_row, row_exp);
                end
                check("key_state", key_state, m_ks);
                check("any_key", any_key, |m_ks);
                check("evt_valid", evt_valid, m_fifo.size() != 0);
                if (m_fifo.size() != 0 && evt_valid) begin
                    check("evt_press", evt_press, m_fifo[0].press);
                    check("evt_code", evt_code, m_fifo[0].code);
                    valid_cycles++;
                end
                check("evt_overflow", evt_overflow, m_ovf);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_frame_start();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (m_fpos != 0 && w < 300);
        check("frame_start_row", kp_row, 4'b1110);
    endtask

    task automatic wait_emit();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (m_fpos <= RS && w < 300);
        check("emit_row_held", kp_row, 4'b1110);
    endtask

    task automatic pop_expect(input string name, input bit press, input int code);
        int w = 0;
        while (!evt_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({name, "_valid"}, evt_valid, 1);
        if (evt_valid) begin
            check({name, "_press"}, evt_press, press);
            check({name, "_code"}, evt_code, code);
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int w;
        int base;
        int idx;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle frame: row strobe sequence, then a quiet UPDATE.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("row_seq", kp_row, row_seq[i/4]);
        end
        @(negedge clk);
        check("idle_valid", evt_valid, 0);
        check("idle_key_state", key_state, 0);

        // Key 6 held from a frame start: key_state at cycle 51, event at 52.
        wait_frame_start();
        keys_down[6] = 1'b1;
        repeat (50) @(negedge clk);
        check("press_ks_before", key_state[6], 0);
        @(negedge clk);
        check("press_ks_rise", key_state[6], 1);
        @(negedge clk);
        check("press_valid", evt_valid, 1);
        check("press_type", evt_press, 1);
        check("press_code", evt_code, 6);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;

        wait_frame_start();
        keys_down[6] = 1'b0;
        pop_expect("release6", 1'b0, 6);

        // Bounce: closed 2, open 1, closed 2, then open.
        wait_frame_start();
        base = valid_cycles;
        keys_down[6] = 1'b1;
        repeat (2) wait_frame_start();
        keys_down[6] = 1'b0;
        wait_frame_start();
        keys_down[6] = 1'b1;
        repeat (2) wait_frame_start();
        keys_down[6] = 1'b0;
        repeat (3) wait_frame_start();
        check("bounce_key", key_state[6], 0);
        check("bounce_no_events", valid_cycles - base, 0);

        // Simultaneous presses of 0, 5, 15 with the consumer always ready.
        wait_frame_start();
        evt_ready = 1'b1;
        keys_down[0] = 1'b1; keys_down[5] = 1'b1; keys_down[15] = 1'b1;
        w = 0;
        while (!evt_valid && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("multi_0_valid", evt_valid, 1);
        check("multi_0_code", evt_code, 0);
        @(negedge clk);
        check("multi_5_valid", evt_valid, 1);
        check("multi_5_code", evt_code, 5);
        @(negedge clk);
        check("multi_15_valid", evt_valid, 1);
        check("multi_15_code", evt_code, 15);
        check("multi_any_key", any_key, 1);
        wait_frame_start();
        keys_down = '0;
        repeat (5) wait_frame_start();
        evt_ready = 1'b0;
        check("multi_drained", evt_valid, 0);

        // Fill the FIFO, then pop+push on a full FIFO must be accepted.
        wait_frame_start();
        keys_down[7:0] = 8'hFF;
        repeat (4) wait_frame_start();
        check("fill_valid", evt_valid, 1);
        check("fill_no_overflow", evt_overflow, 0);
        wait_frame_start();
        keys_down[0] = 1'b0;
        wait_emit();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("full_poppush_no_overflow", evt_overflow, 0);
        for (int k = 1; k < 8; k++) pop_expect("fill_drain", 1'b1, k);
        pop_expect("fill_tail_release0", 1'b0, 0);
        @(negedge clk);
        check("fill_empty", evt_valid, 0);
        evt_ready = 1'b1;
        wait_frame_start();
        keys_down = '0;
        repeat (5) wait_frame_start();
        evt_ready = 1'b0;

        // Nine presses with no consumer: eight kept, ninth dropped.
        wait_frame_start();
        keys_down[8:0] = 9'h1FF;
        repeat (4) wait_frame_start();
        check("ovf_set", evt_overflow, 1);
        for (int k = 0; k < 8; k++) pop_expect("ovf_drain", 1'b1, k);
        repeat (3) @(negedge clk);
        check("ovf_ninth_dropped", evt_valid, 0);
        check("ovf_sticky", evt_overflow, 1);

        // Reset in the middle of EMIT with three events queued.
        wait_frame_start();
        keys_down[4:0] = 5'h00;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(m_fpos > RS && m_fifo.size() == 3) && w < 400);
        check("pre_reset_valid", evt_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", evt_valid, 0);
        check("rst_async_key_state", key_state, 0);
        check("rst_async_overflow", evt_overflow, 0);
        check("rst_async_row", kp_row, 4'b1110);
        keys_down = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_row_seq", kp_row, row_seq[i/4]);
        end

        // Randomised traffic checked cycle by cycle against the model.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (cyc < 1500) evt_ready = ($urandom_range(0, 3) != 0);
            else            evt_ready = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) begin
                idx = int'($urandom_range(0, KEYS - 1));
                keys_down[idx] = ~keys_down[idx];
            end
        end
        evt_ready = 1'b1;
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the game controls. It drives one-cold row strobes and samples active-low column returns. Each key is debounced over whole scan frames, and press/release transitions become coded events. Events are buffered in a small FIFO with a valid/ready handshake toward the game logic. It replaces the fixed two-row, single-key decoder with N×M scanning, multi-key tracking, debouncing and event queuing.

## Interface
- ROWS, 4: keypad rows scanned (≥1).
- COLS, 4: keypad columns sampled (≥1).
- SETTLE, 4: cycles each row is driven before its column sample (≥1).
- DEBOUNCE, 3: consecutive frames a key must disagree with its debounced state before it flips (≥1).
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2).
- KW = clog2(ROWS*COLS) (derived): key-code width.
- clk  in  1  scan clock (100 Hz domain). One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- kp_col  in  COLS  column returns, active-low (0 = key closed on the driven row).
- kp_row  out  ROWS  row strobes, one-cold: bit r low selects row r.
- key_state  out  ROWS*COLS  debounced level per key, bit r*COLS+c, 1 = held.
- any_key  out  1  OR of key_state.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready.
- evt_press  out  1  head event type: 1 = press, 0 = release.
- evt_code  out  KW  head event key code r*COLS+c.
- evt_overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- FSM states SCAN, UPDATE, EMIT. Reset state is SCAN with row 0.
- SCAN: row index r (0..ROWS-1) and dwell counter d (0..SETTLE-1). kp_row = ~(1<<r).
  - At d = SETTLE-1, raw[r*COLS+c] = ~kp_col[c] for all c.
  - At d = SETTLE-1 with r = ROWS-1, go to UPDATE. Otherwise advance r at dwell end.
- UPDATE (1 cycle): for each key k, if raw[k] == key_state[k] then cnt[k] = 0.
  - Otherwise cnt[k]++. If cnt[k] reaches DEBOUNCE, toggle key_state[k], clear cnt[k] and set flip[k].
  - If any flip is set, go to EMIT. Otherwise go to SCAN with r = 0, d = 0.
- EMIT: each cycle, take the lowest set flip index k and push {key_state[k], k}, then clear flip[k].
  - Go to SCAN (r = 0, d = 0) when the last flip is pushed.
  - Scanning is stalled in EMIT. kp_row holds row 0.
- FIFO: FIFO_DEPTH entries of {press, code}. Registered output; a push into an empty FIFO raises evt_valid the next cycle.
  - Pop on evt_valid & evt_ready.
  - Push when full: the event is dropped and evt_overflow is set, except when a pop occurs in the same cycle. In that case the push is accepted.
  - Push and pop on a non-empty, non-full FIFO: occupancy is unchanged and order is preserved.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy uses a KW-independent count of clog2(FIFO_DEPTH)+1 bits.
- evt_overflow clears only on rst.
- Outputs with evt_valid = 0 (evt_press, evt_code) are don't-care.

## Timing
- Reset (async assert, sync deassert by the parent) forces: kp_row = ~1, key_state = 0, any_key = 0, evt_valid = 0, evt_overflow = 0, all cnt/flip/raw = 0, FIFO empty.
- Frame length is ROWS*SETTLE + 1 + F cycles, where F = number of flips in that frame.
- Press latency: a key closed and stable from frame n is seen in raw at frame n. key_state sets at the UPDATE of frame n+DEBOUNCE-1. The event is pushed in the next cycle(s) and is valid one cycle after its push.
- A bounce that returns to the debounced level before DEBOUNCE frames resets cnt and produces no event.
- With simultaneous flips, events are emitted in ascending code order, one per cycle.
- Reset mid-EMIT discards pending flips and FIFO contents.
- key_state and any_key change only on the UPDATE edge.

## Test plan
- Defaults (4×4, SETTLE=4, DEBOUNCE=3, depth 8): reset, then idle kp_col = 4'hF.
  - Required: kp_row cycles 1110→1101→1011→0111, 4 cycles each, then a 1-cycle UPDATE.
  - Required: no events, key_state = 0.
- Hold key r=1, c=2 closed (kp_col[2] = 0 while kp_row = 1101) for 3 frames.
  - Required: key_state[6] rises at the 3rd UPDATE, then evt_valid with evt_press = 1, evt_code = 6.
  - On release for 3 frames: evt_press = 0, evt_code = 6.
- Key 6 closed for 2 frames, open for 1, closed for 2. Required: no event, key_state[6] = 0 throughout.
- Keys 0, 5 and 15 pressed in the same frames with evt_ready = 1.
  - Required: three events, codes 0, 5, 15 in order, on consecutive cycles.
  - Required: any_key = 1.
- evt_ready = 0, then 9 distinct key presses.
  - Required: 8 events retained in order, 9th dropped, evt_overflow = 1 until rst.
  - Required: a simultaneous pop+push on a full FIFO is accepted without overflow.
- Assert rst mid-EMIT with the FIFO holding 3 events.
  - Required: evt_valid = 0 and key_state = 0 immediately (asynchronous).
  - Required: scan restarts at row 0 after deassert.
